// File: rtl/mar_ctrl.sv
// Memory address register controller.
// Holds the current address (loadable from NSRC prioritised sources or
// incrementable), launches single read/write accesses at that address, and
// waits up to TIMEOUT cycles for the memory to acknowledge each access.
module mar_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int NSRC     = 2,
    parameter int TIMEOUT  = 15,
    parameter int AUTO_INC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC*ADDR_W-1:0] src_data,
    input  logic [NSRC-1:0]        src_load,
    input  logic                   inc,
    input  logic                   rd_req,
    input  logic                   wr_req,
    input  logic                   mem_ack,
    output logic [ADDR_W-1:0]      mar_data,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    // Controller states. DONE and ERR each last exactly one cycle and
    // drive the corresponding one-cycle pulse.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    // TIMEOUT is at most 255, so an 8-bit wait counter always suffices.
    localparam int         CNT_W       = 8;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              op_rd;
    logic [ADDR_W-1:0] mar_next;
    logic              start;
    logic              timed_out;

    // Address increment; the natural width of the add gives the
    // all-ones -> zero wrap.
    function automatic logic [ADDR_W-1:0] addr_incr(input logic [ADDR_W-1:0] a);
        return a + ADDR_ONE;
    endfunction

    // Priority select of the load sources: walking from the highest index
    // down lets the lowest-index asserted strobe overwrite the rest.
    function automatic logic [ADDR_W-1:0] pick_src(
        input logic [NSRC*ADDR_W-1:0] data,
        input logic [NSRC-1:0]        load
    );
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (load[i]) begin
                r = data[i*ADDR_W +: ADDR_W];
            end
        end
        return r;
    endfunction

    assign start     = (state == S_IDLE) && (rd_req || wr_req);
    assign timed_out = (wait_cnt == CNT_LIMIT);

    // Next-state decision: accept a request in IDLE, resolve ack/timeout
    // in ACCESS, and return to IDLE after the one-cycle result states.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_next = S_DONE;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next address: loads and inc only act in IDLE (a load beats inc);
    // the only change while busy is the optional post-access increment.
    always_comb begin
        mar_next = mar_data;
        if (state == S_IDLE) begin
            if (|src_load) begin
                mar_next = pick_src(src_data, src_load);
            end else if (inc) begin
                mar_next = addr_incr(mar_data);
            end
        end else if ((state == S_DONE) && (AUTO_INC != 0)) begin
            mar_next = addr_incr(mar_data);
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Access bookkeeping: on acceptance freeze the pre-update address and
    // the operation (read wins when both are requested) and start the wait
    // count at 1; count up through ACCESS until ack or the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            op_rd    <= 1'b0;
            wait_cnt <= '0;
        end else if (start) begin
            mem_addr <= mar_data;
            op_rd    <= rd_req;
            wait_cnt <= CNT_ONE;
        end else if ((state == S_ACCESS) && !mem_ack && !timed_out) begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

    // Address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_data <= '0;
        end else begin
            mar_data <= mar_next;
        end
    end

    // Outputs are decoded straight from the asynchronously reset state, so
    // the strobes drop the moment reset asserts rather than at the next edge.
    assign mem_rd      = (state == S_ACCESS) &&  op_rd;
    assign mem_wr      = (state == S_ACCESS) && !op_rd;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_mar_ctrl.sv
// Testbench for mar_ctrl: a constant vector table for the basic address and
// access behaviour, hand-written timeout/reset sequences, and a randomized
// run compared every cycle against a transaction-level reference model.
// Two instances share the stimulus: one with AUTO_INC=0, one with AUTO_INC=1.
module tb_mar_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] src_data;
    logic [1:0]  src_load;
    logic        inc, rd_req, wr_req, mem_ack;

    logic [7:0]  mar0, addr0, mar1, addr1;
    logic        rd0, wr0, busy0, done0, terr0;
    logic        rd1, wr1, busy1, done1, terr1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mar_ctrl #(.ADDR_W(8), .NSRC(2), .TIMEOUT(15), .AUTO_INC(0)) dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_load(src_load),
        .inc(inc), .rd_req(rd_req), .wr_req(wr_req), .mem_ack(mem_ack),
        .mar_data(mar0), .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0),
        .busy(busy0), .done(done0), .timeout_err(terr0)
    );

    mar_ctrl #(.ADDR_W(8), .NSRC(2), .TIMEOUT(15), .AUTO_INC(1)) dut_ai (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_load(src_load),
        .inc(inc), .rd_req(rd_req), .wr_req(wr_req), .mem_ack(mem_ack),
        .mar_data(mar1), .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1),
        .busy(busy1), .done(done1), .timeout_err(terr1)
    );

    // ---------------- reference model (per instance: 0 plain, 1 auto-inc)
    int m_mar[2];
    int m_addr[2];
    bit m_inflight[2];   // an access is waiting for its ack
    bit m_is_read[2];
    int m_waited[2];     // which ACCESS cycle we are in (1-based)
    int m_result[2];     // 0 none, 1 completion cycle, 2 timeout cycle

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mar[k] = 0; m_addr[k] = 0; m_inflight[k] = 0;
            m_is_read[k] = 0; m_waited[k] = 0; m_result[k] = 0;
        end
    endtask

    task automatic model_tick();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_result[k] != 0) begin
                if (m_result[k] == 1 && k == 1) m_mar[k] = (m_mar[k] + 1) % 256;
                m_result[k] = 0;
            end else if (m_inflight[k]) begin
                if (mem_ack) begin
                    m_inflight[k] = 0; m_result[k] = 1;
                end else if (m_waited[k] == 15) begin
                    m_inflight[k] = 0; m_result[k] = 2;
                end else begin
                    m_waited[k] = m_waited[k] + 1;
                end
            end else begin
                if (rd_req || wr_req) begin
                    m_inflight[k] = 1; m_is_read[k] = rd_req;
                    m_addr[k] = m_mar[k]; m_waited[k] = 1;
                end
                if (src_load[0])      m_mar[k] = int'(src_data[7:0]);
                else if (src_load[1]) m_mar[k] = int'(src_data[15:8]);
                else if (inc)         m_mar[k] = (m_mar[k] + 1) % 256;
            end
        end
    endtask

    function automatic logic [20:0] model_vec(int k);
        logic [7:0] a, b;
        a = 8'(m_mar[k]);
        b = 8'(m_addr[k]);
        return {a, b, m_inflight[k] && m_is_read[k], m_inflight[k] && !m_is_read[k],
                m_inflight[k] || (m_result[k] != 0), m_result[k] == 1, m_result[k] == 2};
    endfunction

    function automatic logic [20:0] dut_vec(int k);
        if (k == 0) return {mar0, addr0, rd0, wr0, busy0, done0, terr0};
        return {mar1, addr1, rd1, wr1, busy1, done1, terr1};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string name);
        check({name, "/plain"},   32'(dut_vec(0)), 32'(model_vec(0)));
        check({name, "/autoinc"}, 32'(dut_vec(1)), 32'(model_vec(1)));
        check({name, "/no_overlap"}, 32'(rd0 & wr0 | rd1 & wr1), 32'd0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step(string name);
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check_model(name);
    endtask

    task automatic idle_inputs();
        src_data = '0; src_load = '0; inc = 0; rd_req = 0; wr_req = 0; mem_ack = 0;
    endtask

    // ---------------- vector table
    typedef struct {
        logic [1:0]  sl;
        logic [15:0] sd;
        logic [3:0]  ctl;     // {inc, rd_req, wr_req, mem_ack}
        logic [7:0]  e_mar;
        logic [7:0]  e_addr;
        logic [4:0]  e_flg;   // {mem_rd, mem_wr, busy, done, timeout_err}
        logic [7:0]  e_mar_ai;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int n;
        tbl[0]  = '{2'b11, 16'h2211, 4'b0000, 8'h11, 8'h00, 5'b00000, 8'h11};
        tbl[1]  = '{2'b10, 16'h2211, 4'b0000, 8'h22, 8'h00, 5'b00000, 8'h22};
        tbl[2]  = '{2'b01, 16'h00FF, 4'b0000, 8'hFF, 8'h00, 5'b00000, 8'hFF};
        tbl[3]  = '{2'b00, 16'h0000, 4'b1000, 8'h00, 8'h00, 5'b00000, 8'h00};
        tbl[4]  = '{2'b01, 16'h00FF, 4'b0000, 8'hFF, 8'h00, 5'b00000, 8'hFF};
        tbl[5]  = '{2'b10, 16'h4000, 4'b1000, 8'h40, 8'h00, 5'b00000, 8'h40};
        tbl[6]  = '{2'b00, 16'h0000, 4'b0000, 8'h40, 8'h00, 5'b00000, 8'h40};
        tbl[7]  = '{2'b01, 16'h0030, 4'b0000, 8'h30, 8'h00, 5'b00000, 8'h30};
        tbl[8]  = '{2'b00, 16'h0000, 4'b0100, 8'h30, 8'h30, 5'b10100, 8'h30};
        tbl[9]  = '{2'b01, 16'h0077, 4'b1000, 8'h30, 8'h30, 5'b10100, 8'h30};
        tbl[10] = '{2'b00, 16'h0000, 4'b0000, 8'h30, 8'h30, 5'b10100, 8'h30};
        tbl[11] = '{2'b00, 16'h0000, 4'b0001, 8'h30, 8'h30, 5'b00110, 8'h30};
        tbl[12] = '{2'b00, 16'h0000, 4'b0100, 8'h30, 8'h30, 5'b00000, 8'h31};
        tbl[13] = '{2'b00, 16'h0000, 4'b0110, 8'h30, 8'h30, 5'b10100, 8'h31};
        tbl[14] = '{2'b10, 16'h5500, 4'b1001, 8'h30, 8'h30, 5'b00110, 8'h31};
        tbl[15] = '{2'b00, 16'h0000, 4'b0001, 8'h30, 8'h30, 5'b00000, 8'h32};
        tbl[16] = '{2'b00, 16'h0000, 4'b1010, 8'h31, 8'h30, 5'b01100, 8'h33};
        tbl[17] = '{2'b00, 16'h0000, 4'b0001, 8'h31, 8'h30, 5'b00110, 8'h33};
        tbl[18] = '{2'b00, 16'h0000, 4'b0000, 8'h31, 8'h30, 5'b00000, 8'h34};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(dut_vec(0)), 32'd0);
        check("reset_state_ai", 32'(dut_vec(1)), 32'd0);
        rst_n = 1'b1;

        // Table: each row is one cycle of inputs and the outputs after the edge
        for (int i = 0; i < 19; i++) begin
            src_load = tbl[i].sl;
            src_data = tbl[i].sd;
            {inc, rd_req, wr_req, mem_ack} = tbl[i].ctl;
            step($sformatf("row%0d_model", i));
            check($sformatf("row%0d", i), 32'({mar0, addr0, rd0, wr0, busy0, done0, terr0}),
                  32'({tbl[i].e_mar, tbl[i].e_addr, tbl[i].e_flg}));
            check($sformatf("row%0d_ai_mar", i), 32'(mar1), 32'(tbl[i].e_mar_ai));
        end
        idle_inputs();

        // Timeout: write, never acked -> 15 cycles of mem_wr, then one error pulse
        wr_req = 1;
        step("to_req");
        wr_req = 0;
        n = 0;
        while (wr0 === 1'b1 && n < 40) begin
            n++;
            step("to_wait");
        end
        check("to_wr_cycles", 32'(n), 32'd15);
        check("to_err_pulse", 32'({terr0, done0, busy0, wr0}), 32'b1010);
        check("to_mar_kept", 32'(mar0), 32'h31);
        step("to_after");
        check("to_err_one_cycle", 32'({terr0, busy0}), 32'b00);

        // Ack in the final permitted cycle still completes
        rd_req = 1;
        step("late_req");
        rd_req = 0;
        repeat (14) step("late_wait");
        mem_ack = 1;
        step("late_ack");
        mem_ack = 0;
        check("late_ack_done", 32'({done0, terr0}), 32'b10);
        step("late_after");

        // Reset during ACCESS: strobes and busy drop without waiting for an edge
        rd_req = 1;
        step("rst_req");
        rd_req = 0;
        step("rst_wait");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_plain", 32'(dut_vec(0)), 32'd0);
        check("rst_async_ai", 32'(dut_vec(1)), 32'd0);
        step("rst_held");
        rst_n = 1'b1;
        mem_ack = 1;
        repeat (3) step("rst_release");
        mem_ack = 0;

        // Randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            int ack_div;
            ack_div = ((c / 500) % 2 == 0) ? 3 : 30;
            src_data = 16'($urandom);
            src_load = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            inc      = ($urandom_range(0, 3) == 0);
            rd_req   = ($urandom_range(0, 3) == 0);
            wr_req   = ($urandom_range(0, 3) == 0);
            mem_ack  = ($urandom_range(0, ack_div - 1) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_model("rand_async_rst");
                #1;
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
